instr_fetch_unit: RTL

//  Fetch stage feeding the instruction decoder: owns the PC, issues single-word reads to a

---
 rtl/fetch_pkg.sv | 17 +
 rtl/pc_reg.sv | 42 ++++
 rtl/instr_fetch_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    VALID  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam logic [4:0] OPC_HALT = 5'b00000;
  localparam logic [4:0] OPC_NOP  = 5'b00001;

  localparam int unsigned PC_W_DEF    = 16;
  localparam int unsigned INSTR_W_DEF = 16;

endpackage

// File: rtl/pc_reg.sv
// Program counter: reset value, redirect load (highest priority) and +2 step on consume.
module pc_reg #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_pc_i,
  input  logic            inc_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_plus2_o
);

  localparam logic [PC_W-1:0] PC_STEP = {{(PC_W-2){1'b0}}, 2'b10};

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_STEP;
    end else begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus2_o = pc_q + PC_STEP;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC ownership, single-word imem reads, instruction hand-off, redirect and halt.
// Define ALIGN_CHECK_EN to fault on odd PCs; otherwise imem_addr[0] is forced low.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter int unsigned     INSTR_W  = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd,
  input  logic               imem_stall,
  input  logic               imem_done,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc_plus2,
  input  logic               dec_stall,
  input  logic               halt,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted,
  output logic               err
);

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               squash_q, squash_d;
  logic               err_q, err_d;
  logic               instr_valid_q;
  logic               halted_q;
  logic               pc_load_s;
  logic               pc_inc_s;
  logic               rd_s;
  logic               align_fault_s;
  logic [PC_W-1:0]    pc_s;

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pc_load_s),
    .load_pc_i  (redirect_pc),
    .inc_i      (pc_inc_s),
    .pc_o       (pc_s),
    .pc_plus2_o (pc_plus2)
  );

`ifdef ALIGN_CHECK_EN
  assign align_fault_s = pc_s[0];
  assign imem_addr     = pc_s;
`else
  assign align_fault_s = 1'b0;
  assign imem_addr     = pc_s & ~{{(PC_W-1){1'b0}}, 1'b1};
`endif

  // Redirect is checked first in every live state so it beats done, halt and consume.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    squash_d  = squash_q;
    err_d     = err_q;
    pc_load_s = 1'b0;
    pc_inc_s  = 1'b0;
    rd_s      = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_load_s = 1'b1;
          state_d   = FETCH;
        end else if (align_fault_s) begin
          err_d   = 1'b1;
          state_d = HALTED;
        end else begin
          rd_s    = 1'b1;
          state_d = imem_stall ? FETCH : WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_load_s = 1'b1;
          if (imem_done) begin
            squash_d = 1'b0;
            state_d  = FETCH;
          end else begin
            squash_d = 1'b1;
            state_d  = WAIT;
          end
        end else if (imem_done) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = FETCH;
          end else begin
            instr_d = imem_rdata;
            state_d = VALID;
          end
        end else begin
          state_d = WAIT;
        end
      end
      VALID: begin
        if (redirect) begin
          pc_load_s = 1'b1;
          state_d   = FETCH;
        end else if (!dec_stall) begin
          if (halt) begin
            state_d = HALTED;
          end else begin
            pc_inc_s = 1'b1;
            state_d  = FETCH;
          end
        end else begin
          state_d = VALID;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Fetch state, held instruction and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      instr_q       <= {INSTR_W{1'b0}};
      squash_q      <= 1'b0;
      err_q         <= 1'b0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      squash_q      <= squash_d;
      err_q         <= err_d;
      instr_valid_q <= (state_d == VALID);
      halted_q      <= (state_d == HALTED);
    end
  end

  assign imem_rd     = rd_s & ~rst;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign err         = err_q;

endmodule
